mem_access_unit: RTL
====================

# mem_access_unit

Load/store access unit placed between the multicycle datapath and the unified instruction/data memory. It accepts one memory request at a time from the datapath control FSM. It drives a synchronous SRAM with fixed read latency and handles RV32I byte, halfword and word access. It returns sign- or zero-extended load data with a single-cycle `done` pulse that the control FSM waits on before leaving its memory state.

## Interface
- `RAM_LATENCY`, default 1: SRAM read latency in cycles from the `ram_en` edge to valid `ram_rdata`; legal range 1..4.
- `RAM_AW`, default 10: SRAM word-address width.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req`  in  1  request strobe; sampled only while `busy`=0.
- `write`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RV32I width/sign field.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data, right-aligned.
- `busy`  out  1  request in flight.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  misaligned access; valid only with `done`.
- `rdata`  out  32  extended load result; held until the next accept.
- `ram_en`  out  1  SRAM access strobe.
- `ram_we`  out  4  SRAM byte-write mask.
- `ram_addr`  out  RAM_AW  SRAM word address, `addr[RAM_AW+1:2]`.
- `ram_wdata`  out  32  lane-replicated store data.
- `ram_rdata`  in  32  SRAM read data.

## Operation
- States are IDLE, ISSUE, WAIT, DONE.
- Accept: `req`=1 in IDLE or DONE. Registers `write`, `funct3`, `addr` and `wdata` at the accept edge. The datapath may change its inputs afterwards.
- Requests arriving while `busy`=1 are ignored, not queued.
- ISSUE lasts one cycle:
  - `ram_en`=1.
  - Store: `ram_we` holds the lane mask and the next state is DONE.
  - Load: `ram_we`=0 and the next state is WAIT.
- WAIT: a down-counter loaded with RAM_LATENCY-1. At count 0, capture `ram_rdata` and go to DONE.
- DONE lasts one cycle with `done`=1 and `busy`=0. Next state is ISSUE on a new accept, otherwise IDLE.
- funct3 width:
  - 000 = byte signed.
  - 001 = half signed.
  - 010 = word.
  - 100 = byte unsigned.
  - 101 = half unsigned.
  - 011, 110 and 111 are treated as word.
- Lanes: byte lane n = `addr[1:0]`, bits 8n+7:8n.
  - Store byte: `ram_wdata`={4{wdata[7:0]}}, `ram_we`=0001<<n.
  - Store half: `ram_wdata`={2{wdata[15:0]}}, `ram_we`=0011<<(`addr[1]`*2).
  - Store word: `ram_we`=1111.
- Load: select the lane from the captured word, then sign-extend for 000/001 or zero-extend for 100/101.
- `ram_en`, `ram_we` and `ram_wdata` are 0 outside ISSUE. `ram_addr` holds the last value.

## Timing
- Edge k ends cycle k. Accept happens at edge 0.
  - Cycle 1: ISSUE.
  - Store: `done` in cycle 2.
  - Load: `ram_rdata` sampled at edge 1+RAM_LATENCY, `done` and valid `rdata` in cycle 2+RAM_LATENCY.
- `busy`=1 from cycle 1 through the cycle before `done`.
- Back-to-back: an accept at the edge ending DONE puts ISSUE in the following cycle, so there are no idle bubbles.
- Reset (`reset_n`=0 at an edge) forces IDLE with outputs as follows:
  - `busy`, `done`, `fault`, `ram_en` = 0.
  - `ram_we`, `rdata`, `ram_wdata`, `ram_addr` and the counter = 0.
- Reset mid-access aborts it. Any in-flight SRAM response is ignored and `done` is never pulsed for the aborted request.

## Configuration
- Macro: `MEM_MISALIGN_TRAP_EN`.
- Defined: a half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - No SRAM access is made: the unit skips ISSUE and goes straight to DONE.
  - `done`=1 and `fault`=1 in cycle 1.
  - `rdata`=0.
- Undefined:
  - `fault` is tied 0.
  - Half access uses `addr[1]` with `addr[0]` ignored.
  - Word access ignores `addr[1:0]`.
  - Latency is identical to the aligned case.

## Test plan
- Reset with RAM_LATENCY=2: hold `reset_n`=0 for 2 cycles. All outputs must be 0 and `busy`=0.
- Store word 0xDEADBEEF to 0x100 → `ram_en`=1, `ram_we`=1111, `ram_addr`=0x40 in cycle 1; `done` in cycle 2.
- Byte RAM word 0x8000_7F80, RAM_LATENCY=2:
  - LB at offset 0 → `rdata`=0xFFFF_FF80.
  - LBU at offset 0 → `rdata`=0x0000_0080.
  - LH at offset 2 → `rdata`=0xFFFF_8000.
  - Each `done` arrives in cycle 4.
- SB 0xAB at 0x103 → `ram_we`=1000, `ram_wdata`=0xABABABAB. Follow-up LW at the edge ending DONE → ISSUE in the next cycle with no bubble.
- Misaligned LW at 0x102:
  - With `MEM_MISALIGN_TRAP_EN`: `done` and `fault` in cycle 1, `ram_en` never asserted.
  - Without it: a normal word read of 0x100 is made and `fault`=0.
- Assert `reset_n`=0 during WAIT → next cycle IDLE with `done` never pulsed. A new LW then completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I byte/half/word load-store unit for a synchronous SRAM; one request at a time, requests while busy are dropped.
// Latency: store done in cycle 2, load in cycle 2+RAM_LATENCY; MEM_MISALIGN_TRAP_EN faults misaligned half/word accesses in cycle 1.
module mem_access_unit #(
  parameter int RAM_LATENCY = 1,
  parameter int RAM_AW      = 10
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [31:0]       o_rdata,
  output logic              o_ram_en,
  output logic [3:0]        o_ram_we,
  output logic [RAM_AW-1:0] o_ram_addr,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [RAM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [1:0]        r_cnt;
  logic              w_accept;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [3:0]        w_we;
  logic [31:0]       w_wdata;
  logic              w_unused_addr;

  assign w_accept      = i_req && (r_state == S_IDLE || r_state == S_DONE);
  assign w_unused_addr = ^i_addr[31:RAM_AW+2];

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_fault;
  assign w_misalign = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                      (i_funct3[1] && i_addr[1:0] != 2'b00);
  assign o_fault    = (r_state == S_DONE) && r_fault;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n)    r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_misalign;
  end
`else
  assign w_misalign = 1'b0;
  assign o_fault    = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_accept ? (w_misalign ? S_DONE : S_ISSUE) : S_IDLE;
      S_ISSUE:        w_next = r_write ? S_DONE : S_WAIT;
      S_WAIT:         if (r_cnt == 2'd0) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Store lanes: narrow data is replicated so the byte mask alone picks the lane.
  always_comb begin
    w_we    = 4'b0000;
    w_wdata = 32'h0;
    if (r_state == S_ISSUE && r_write) begin
      case (r_funct3[1:0])
        2'b00: begin
          w_wdata = {4{r_wdata[7:0]}};
          w_we    = 4'b0001 << r_addr[1:0];
        end
        2'b01: begin
          w_wdata = {2{r_wdata[15:0]}};
          w_we    = r_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_wdata = r_wdata;
          w_we    = 4'b1111;
        end
      endcase
    end
  end

  assign w_byte = 8'(i_ram_rdata >> {r_addr[1:0], 3'b000});
  assign w_half = 16'(i_ram_rdata >> {r_addr[1], 4'b0000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = i_ram_rdata;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_cnt    <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write  <= i_write;
        r_funct3 <= i_funct3;
        r_addr   <= i_addr[RAM_AW+1:0];
        r_wdata  <= i_wdata;
        if (w_misalign) r_rdata <= 32'h0;
      end
      // Counter spans the remaining SRAM latency after the issue cycle.
      if (r_state == S_ISSUE)
        r_cnt <= 2'(RAM_LATENCY - 1);
      else if (r_state == S_WAIT && r_cnt != 2'd0)
        r_cnt <= r_cnt - 2'd1;
      if (r_state == S_WAIT && r_cnt == 2'd0)
        r_rdata <= w_load;
    end
  end

  assign o_busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_done      = (r_state == S_DONE);
  assign o_rdata     = r_rdata;
  assign o_ram_en    = (r_state == S_ISSUE);
  assign o_ram_we    = w_we;
  assign o_ram_wdata = w_wdata;
  assign o_ram_addr  = r_addr[RAM_AW+1:2];

endmodule
